uart_tx_fifo: RTL and testbench

// - Buffered UART transmitter: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first.
// - Host logic writes bytes into an internal FIFO. The TX engine drains the FIFO back-to-back

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to uart_tx_fifo and uart_rx, and default bit timing.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    s_IDLE         = 3'b000,
    s_TX_START_BIT = 3'b001,
    s_TX_DATA_BITS = 3'b010,
    s_TX_STOP_BIT  = 3'b011,
    s_CLEANUP      = 3'b100
  } uart_sm_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle of the buffered UART transmitter: write handshake plus serial line and status.
interface uart_tx_fifo_if #(parameter int FIFO_AW = 4);

  logic               i_Tx_DV;
  logic [7:0]         i_Tx_Byte;
  logic               o_Tx_Ready;
  logic               o_Tx_Serial;
  logic               o_Tx_Active;
  logic               o_Tx_Done;
  logic [FIFO_AW:0]   o_Fifo_Count;
  logic [2:0]         o_Tx_SM;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count, o_Tx_SM
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count, o_Tx_SM
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; writes to a full FIFO and reads from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Extra pointer MSB distinguishes full from empty when the low bits match
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB first, back-to-back.
// First start bit appears one edge after the accepting write; o_Tx_Ready drops while the FIFO is full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = 4
) (
  input logic          i_Clock,
  input logic          i_Reset,
  uart_tx_fifo_if.slave tx_if
);

  localparam int               CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [FIFO_AW:0] DEPTH    = (FIFO_AW+1)'(2**FIFO_AW);

  uart_sm_t         sm;
  logic [CW-1:0]    clk_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       shift_dat;
  logic             serial_q;
  logic             active_q;
  logic             done_q;
  logic             ready_q;

  logic             fifo_wr;
  logic             fifo_rd;
  logic [7:0]       fifo_rd_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic [FIFO_AW:0] count_nxt;

  assign fifo_wr = tx_if.i_Tx_DV & ready_q & ~fifo_full;
  assign fifo_rd = (sm == s_IDLE) & ~fifo_empty;
  assign idx_nxt = bit_idx + 3'd1;

  // Ready is registered, so it is derived from the occupancy after this edge
  assign count_nxt = fifo_count + {{FIFO_AW{1'b0}}, fifo_wr} - {{FIFO_AW{1'b0}}, fifo_rd};

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .wr_en   (fifo_wr),
    .wr_data (tx_if.i_Tx_Byte),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_dat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sm        <= s_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_dat <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      ready_q <= (count_nxt != DEPTH);
      case (sm)
        s_IDLE: begin
          serial_q <= 1'b1;
          done_q   <= 1'b0;
          clk_cnt  <= '0;
          bit_idx  <= '0;
          if (!fifo_empty) begin
            shift_dat <= fifo_rd_dat;
            serial_q  <= 1'b0;
            active_q  <= 1'b1;
            sm        <= s_TX_START_BIT;
          end
        end
        s_TX_START_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            serial_q <= shift_dat[0];
            sm       <= s_TX_DATA_BITS;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        s_TX_DATA_BITS: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx  <= '0;
              serial_q <= 1'b1;
              sm       <= s_TX_STOP_BIT;
            end else begin
              bit_idx  <= idx_nxt;
              serial_q <= shift_dat[idx_nxt];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        s_TX_STOP_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            done_q   <= 1'b1;
            active_q <= 1'b0;
            sm       <= s_CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        s_CLEANUP: begin
          done_q   <= 1'b0;
          serial_q <= 1'b1;
          sm       <= s_IDLE;
        end
        default: begin
          sm       <= s_IDLE;
          serial_q <= 1'b1;
          active_q <= 1'b0;
          done_q   <= 1'b0;
          clk_cnt  <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  assign tx_if.o_Tx_Ready   = ready_q;
  assign tx_if.o_Tx_Serial  = serial_q;
  assign tx_if.o_Tx_Active  = active_q;
  assign tx_if.o_Tx_Done    = done_q;
  assign tx_if.o_Fifo_Count = fifo_count;
  assign tx_if.o_Tx_SM      = sm;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit and a 16-deep FIFO.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic i_Clock = 1'b0;
  logic i_Reset = 1'b1;

  always #5 i_Clock = ~i_Clock;

  uart_tx_fifo_if #(.FIFO_AW(AW)) tx_if ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .tx_if   (tx_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] stim_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents stim_q on consecutive edges with i_Tx_DV held high throughout
  task automatic drive_stim();
    for (int i = 0; i < stim_q.size(); i++) begin
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = stim_q[i];
      @(posedge i_Clock);
      #1;
    end
    tx_if.i_Tx_DV = 1'b0;
  endtask

  // Waits for the start bit, then checks all 42 cycles of one frame plus its gap
  task automatic check_frame(input logic [7:0] b, input int max_wait, output int waited);
    logic [7:0] bb;
    logic       exp_ser;
    bb     = b;
    waited = 0;
    @(negedge i_Clock);
    while (tx_if.o_Tx_Serial !== 1'b0 && waited < max_wait) begin
      waited++;
      @(negedge i_Clock);
    end
    if (tx_if.o_Tx_Serial !== 1'b0) begin
      chk($sformatf("frame_start b=%02h", b), {31'd0, tx_if.o_Tx_Serial}, 32'd0);
      return;
    end
    for (int k = 0; k < 42; k++) begin
      if (k > 0) @(negedge i_Clock);
      if (k < 4)       exp_ser = 1'b0;
      else if (k < 36) exp_ser = bb[(k - 4) / 4];
      else             exp_ser = 1'b1;
      chk($sformatf("serial b=%02h k=%0d", b, k), {31'd0, tx_if.o_Tx_Serial}, {31'd0, exp_ser});
      chk($sformatf("done b=%02h k=%0d", b, k), {31'd0, tx_if.o_Tx_Done}, (k == 40) ? 32'd1 : 32'd0);
      chk($sformatf("active b=%02h k=%0d", b, k), {31'd0, tx_if.o_Tx_Active}, (k < 40) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tx_if.i_Tx_DV   = 1'b0;
    tx_if.i_Tx_Byte = 8'h00;

    // Reset values, then a long idle stretch
    repeat (3) @(negedge i_Clock);
    chk("rst_serial", {31'd0, tx_if.o_Tx_Serial}, 32'd1);
    chk("rst_ready",  {31'd0, tx_if.o_Tx_Ready},  32'd1);
    chk("rst_active", {31'd0, tx_if.o_Tx_Active}, 32'd0);
    chk("rst_done",   {31'd0, tx_if.o_Tx_Done},   32'd0);
    chk("rst_count",  {27'd0, tx_if.o_Fifo_Count}, 32'd0);
    chk("rst_sm",     {29'd0, tx_if.o_Tx_SM},     32'd0);
    i_Reset = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge i_Clock);
      chk("idle_serial", {31'd0, tx_if.o_Tx_Serial}, 32'd1);
      chk("idle_ready",  {31'd0, tx_if.o_Tx_Ready},  32'd1);
      chk("idle_count",  {27'd0, tx_if.o_Fifo_Count}, 32'd0);
      chk("idle_sm",     {29'd0, tx_if.o_Tx_SM},     32'd0);
    end

    // Single byte 0xA5: latency, bit order, done timing
    stim_q = '{8'hA5};
    drive_stim();
    chk("a5_count_after_write", {27'd0, tx_if.o_Fifo_Count}, 32'd1);
    check_frame(8'hA5, 10, w);
    chk("a5_start_latency", w, 32'd1);
    chk("a5_count_after", {27'd0, tx_if.o_Fifo_Count}, 32'd0);

    // Three back-to-back frames, 42 cycles apart
    stim_q = '{8'h00, 8'hFF, 8'h55};
    fork
      drive_stim();
      begin
        check_frame(8'h00, 10, w);
        chk("b2b_first_latency", w, 32'd1);
        check_frame(8'hFF, 3, w);
        chk("b2b_gap_ff", w, 32'd0);
        check_frame(8'h55, 3, w);
        chk("b2b_gap_55", w, 32'd0);
      end
    join

    // Write on the same edge as an IDLE pop with one byte queued
    stim_q = '{8'h81, 8'h7E};
    fork
      begin
        tx_if.i_Tx_DV   = 1'b1;
        tx_if.i_Tx_Byte = 8'h81;
        @(posedge i_Clock);
        #1;
        chk("same_edge_count_before", {27'd0, tx_if.o_Fifo_Count}, 32'd1);
        tx_if.i_Tx_Byte = 8'h7E;
        @(posedge i_Clock);
        #1;
        tx_if.i_Tx_DV = 1'b0;
        chk("same_edge_count_after", {27'd0, tx_if.o_Fifo_Count}, 32'd1);
      end
      begin
        check_frame(8'h81, 10, w);
        chk("same_edge_latency", w, 32'd1);
        check_frame(8'h7E, 3, w);
        chk("same_edge_gap", w, 32'd0);
      end
    join

    // Hold i_Tx_DV for 20 edges: 17 accepted (one popped early), 3 dropped
    stim_q = {};
    for (int i = 0; i < 20; i++) stim_q.push_back(8'h10 + 8'(i));
    fork
      begin
        drive_stim();
        chk("fill_ready_low", {31'd0, tx_if.o_Tx_Ready},  32'd0);
        chk("fill_count",     {27'd0, tx_if.o_Fifo_Count}, 32'd16);
      end
      begin
        check_frame(8'h10, 10, w);
        chk("fill_latency", w, 32'd1);
        chk("fill_count_after_f1", {27'd0, tx_if.o_Fifo_Count}, 32'd16);
        check_frame(8'h11, 3, w);
        chk("fill_gap_11", w, 32'd0);
        chk("fill_count_after_f2", {27'd0, tx_if.o_Fifo_Count}, 32'd15);
        chk("fill_ready_back",     {31'd0, tx_if.o_Tx_Ready},  32'd1);
        for (int i = 2; i < 17; i++) begin
          check_frame(8'h10 + 8'(i), 3, w);
          chk($sformatf("fill_gap_%0d", i), w, 32'd0);
        end
      end
    join
    for (int c = 0; c < 60; c++) begin
      @(negedge i_Clock);
      chk("fill_no_extra_frame", {31'd0, tx_if.o_Tx_Serial}, 32'd1);
    end
    chk("fill_count_end", {27'd0, tx_if.o_Fifo_Count}, 32'd0);

    // Reset during data bit 3 of 0xC3 with one byte still queued
    stim_q = '{8'hC3, 8'h3C};
    drive_stim();
    repeat (18) @(negedge i_Clock);
    chk("mid_serial_bit3", {31'd0, tx_if.o_Tx_Serial}, 32'd0);
    chk("mid_sm_data",     {29'd0, tx_if.o_Tx_SM},     32'd2);
    chk("mid_count",       {27'd0, tx_if.o_Fifo_Count}, 32'd1);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("arst_serial", {31'd0, tx_if.o_Tx_Serial}, 32'd1);
    chk("arst_count",  {27'd0, tx_if.o_Fifo_Count}, 32'd0);
    chk("arst_sm",     {29'd0, tx_if.o_Tx_SM},     32'd0);
    chk("arst_active", {31'd0, tx_if.o_Tx_Active}, 32'd0);
    chk("arst_ready",  {31'd0, tx_if.o_Tx_Ready},  32'd1);
    repeat (3) begin
      @(negedge i_Clock);
      chk("arst_hold_done", {31'd0, tx_if.o_Tx_Done}, 32'd0);
    end
    i_Reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_Clock);
      chk("post_rst_serial", {31'd0, tx_if.o_Tx_Serial}, 32'd1);
      chk("post_rst_done",   {31'd0, tx_if.o_Tx_Done},   32'd0);
    end
    stim_q = '{8'h96};
    drive_stim();
    check_frame(8'h96, 10, w);
    chk("post_rst_latency", w, 32'd1);
    chk("post_rst_count", {27'd0, tx_if.o_Fifo_Count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
